// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board controller.
//   - cell codes, FSM state encoding, winner encodings
//   - default cell colours
//   - line table: the 8 winning lines as cell-index triples, ordered rows,
//     columns, diag A1-C3, diag A3-C1 (the order decides which line is
//     reported when more than one completes on the same move)
// Cell index: 0=A1 1=A2 2=A3 3=B1 4=B2 5=B3 6=C1 7=C2 8=C3.
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam logic [2:0] DEF_EMPTY_COLOR = 3'b000;
  localparam logic [2:0] DEF_P1_COLOR    = 3'b100;
  localparam logic [2:0] DEF_P2_COLOR    = 3'b001;
  localparam logic [2:0] DEF_WIN_COLOR   = 3'b010;

  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},  // row A
    '{4'd3, 4'd4, 4'd5},  // row B
    '{4'd6, 4'd7, 4'd8},  // row C
    '{4'd0, 4'd3, 4'd6},  // col 1
    '{4'd1, 4'd4, 4'd7},  // col 2
    '{4'd2, 4'd5, 4'd8},  // col 3
    '{4'd0, 4'd4, 4'd8},  // diag A1-C3
    '{4'd2, 4'd4, 4'd6}   // diag A3-C1
  };

  // Code written into the board by the player whose turn it is.
  function automatic logic [1:0] player_code(input logic turn);
    return turn ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line evaluator.
//   board    : 9 x 2-bit cell codes, cell i at board[2i+1:2i]
//   player   : code to look for (P1 or P2)
//   win      : some line is fully owned by player
//   win_mask : cells of the first complete line in table order
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic        win,
  output logic [8:0]  win_mask
);

  logic [NUM_LINES-1:0] line_hit;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign line_hit[l] = (player != CELL_EMPTY) &&
                         (board[2*LINE_TBL[l][0] +: 2] == player) &&
                         (board[2*LINE_TBL[l][1] +: 2] == player) &&
                         (board[2*LINE_TBL[l][2] +: 2] == player);
  end

  // Scan from the last line down so the lowest-numbered hit is kept.
  always_comb begin
    win      = 1'b0;
    win_mask = '0;
    for (int l = NUM_LINES-1; l >= 0; l--) begin
      if (line_hit[l]) begin
        win      = 1'b1;
        win_mask = '0;
        for (int k = 0; k < 3; k++) win_mask[LINE_TBL[l][k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state controller feeding the VGA display block.
//   clk, rst (async, active low)
//   cell_sel  : target cell 0..8 (9..15 rejected)
//   place     : place button level; a rising level is one press
//   new_game  : clear the board, overrides any press
//   A1..C3_color : registered per-cell colour
//   turn, game_over, winner : game status, updated when a move is checked
//   bad_move  : one-cycle pulse on a rejected press
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter logic [2:0] EMPTY_COLOR = DEF_EMPTY_COLOR,
  parameter logic [2:0] P1_COLOR    = DEF_P1_COLOR,
  parameter logic [2:0] P2_COLOR    = DEF_P2_COLOR,
  parameter logic [2:0] WIN_COLOR   = DEF_WIN_COLOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cell_sel,
  input  logic       place,
  input  logic       new_game,
  output logic [2:0] A1_color,
  output logic [2:0] A2_color,
  output logic [2:0] A3_color,
  output logic [2:0] B1_color,
  output logic [2:0] B2_color,
  output logic [2:0] B3_color,
  output logic [2:0] C1_color,
  output logic [2:0] C2_color,
  output logic [2:0] C3_color,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       bad_move
);

  state_t                   state, state_nxt;
  logic [NUM_CELLS-1:0][1:0] board, board_nxt;
  logic [8:0]               win_mask, win_mask_nxt;
  logic [3:0]               move_cnt;
  logic                     place_q;
  logic                     press, cell_free, do_place;
  logic                     lc_win;
  logic [8:0]               lc_mask;
  logic [NUM_CELLS-1:0][2:0] color_nxt, color_q;

  assign press = place & ~place_q;

  // Guarded lookup so illegal indices never read past the board.
  always_comb begin
    cell_free = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (cell_sel == 4'(i)) cell_free = (board[i] == CELL_EMPTY);
  end

  assign do_place = (state == ST_PLAY) && press && cell_free && !new_game;

  ttt_line_check u_line_check (
    .board    (board),
    .player   (player_code(turn)),
    .win      (lc_win),
    .win_mask (lc_mask)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_PLAY;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PLAY:  if (press && cell_free) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (lc_win)                state_nxt = ST_WIN;
        else if (move_cnt == 4'd9) state_nxt = ST_DRAW;
        else                       state_nxt = ST_PLAY;
      end
      default:  state_nxt = state;
    endcase
    if (new_game) state_nxt = ST_PLAY;
  end

  // Output logic: next board/mask and the colours derived from them, so the
  // registered colour lands on the same edge as the board write.
  always_comb begin
    board_nxt    = board;
    win_mask_nxt = win_mask;
    if (new_game) begin
      board_nxt    = '0;
      win_mask_nxt = '0;
    end else begin
      if (do_place)
        for (int i = 0; i < NUM_CELLS; i++)
          if (cell_sel == 4'(i)) board_nxt[i] = player_code(turn);
      if (state == ST_CHECK && lc_win) win_mask_nxt = lc_mask;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (state_nxt == ST_WIN && win_mask_nxt[i]) color_nxt[i] = WIN_COLOR;
      else case (board_nxt[i])
        CELL_P1: color_nxt[i] = P1_COLOR;
        CELL_P2: color_nxt[i] = P2_COLOR;
        default: color_nxt[i] = EMPTY_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board     <= '0;
      win_mask  <= '0;
      move_cnt  <= '0;
      turn      <= 1'b0;
      winner    <= WINNER_NONE;
      game_over <= 1'b0;
      bad_move  <= 1'b0;
      place_q   <= 1'b0;
      color_q   <= {NUM_CELLS{EMPTY_COLOR}};
    end else begin
      place_q  <= place;
      board    <= board_nxt;
      win_mask <= win_mask_nxt;
      color_q  <= color_nxt;
      bad_move <= !new_game && (state == ST_PLAY) && press && !cell_free;
      if (new_game) begin
        move_cnt  <= '0;
        turn      <= 1'b0;
        winner    <= WINNER_NONE;
        game_over <= 1'b0;
      end else begin
        if (do_place) move_cnt <= move_cnt + 4'd1;
        if (state == ST_CHECK) begin
          if (lc_win) begin
            winner    <= turn ? WINNER_P2 : WINNER_P1;
            game_over <= 1'b1;
          end else if (move_cnt == 4'd9) begin
            winner    <= WINNER_DRAW;
            game_over <= 1'b1;
          end else begin
            turn <= ~turn;
          end
        end
      end
    end
  end

  assign A1_color = color_q[0];
  assign A2_color = color_q[1];
  assign A3_color = color_q[2];
  assign B1_color = color_q[3];
  assign B2_color = color_q[4];
  assign B3_color = color_q[5];
  assign C1_color = color_q[6];
  assign C2_color = color_q[7];
  assign C3_color = color_q[8];

endmodule

// File: tb/tb_ttt_board_ctrl.sv
module tb_ttt_board_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cell_sel = '0;
  logic       place = 1'b0;
  logic       new_game = 1'b0;
  logic [2:0] A1_color, A2_color, A3_color, B1_color, B2_color, B3_color;
  logic [2:0] C1_color, C2_color, C3_color;
  logic       turn, game_over, bad_move;
  logic [1:0] winner;

  always #5 clk = ~clk;

  ttt_board_ctrl dut (
    .clk(clk), .rst(rst), .cell_sel(cell_sel), .place(place), .new_game(new_game),
    .A1_color(A1_color), .A2_color(A2_color), .A3_color(A3_color),
    .B1_color(B1_color), .B2_color(B2_color), .B3_color(B3_color),
    .C1_color(C1_color), .C2_color(C2_color), .C3_color(C3_color),
    .turn(turn), .game_over(game_over), .winner(winner), .bad_move(bad_move)
  );

  logic [8:0][2:0] dut_col;
  assign dut_col = {C3_color, C2_color, C1_color, B3_color, B2_color, B1_color,
                    A3_color, A2_color, A1_color};

  // Reference model: board as plain ints (0 empty, 1 P1, 2 P2).
  int       m_cell [9];
  int       m_turn, m_cnt, m_winner;
  bit       m_over, m_pending, m_bad, m_prev;
  bit [8:0] m_mask;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cell k (0..2) of line l, lines ordered rows, cols, diag, anti-diag.
  function automatic int line_cell(input int l, input int k);
    if (l < 3) return l*3 + k;
    if (l < 6) return (l-3) + 3*k;
    if (l == 6) return 4*k;
    return 2 + 2*k;
  endfunction

  function automatic int first_line(input int code);
    for (int l = 0; l < 8; l++)
      if (m_cell[line_cell(l,0)] == code && m_cell[line_cell(l,1)] == code &&
          m_cell[line_cell(l,2)] == code) return l;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_turn = 0; m_cnt = 0; m_winner = 0; m_over = 0;
    m_pending = 0; m_bad = 0; m_mask = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_prev = 0;
  endtask

  task automatic model_step(input int s, input bit p, input bit n);
    bit pr;
    int l;
    pr = p && !m_prev;
    m_prev = p;
    m_bad = 0;
    if (n) begin
      model_clear();
    end else if (m_pending) begin
      m_pending = 0;
      l = first_line(m_turn + 1);
      if (l >= 0) begin
        m_over = 1; m_winner = m_turn + 1;
        for (int k = 0; k < 3; k++) m_mask[line_cell(l,k)] = 1'b1;
      end else if (m_cnt == 9) begin
        m_over = 1; m_winner = 3;
      end else begin
        m_turn = 1 - m_turn;
      end
    end else if (!m_over && pr) begin
      if (s <= 8 && m_cell[s] == 0) begin
        m_cell[s] = m_turn + 1; m_cnt++; m_pending = 1;
      end else begin
        m_bad = 1;
      end
    end
  endtask

  function automatic logic [2:0] exp_col(input int i);
    if ((m_winner == 1 || m_winner == 2) && m_mask[i]) return 3'b010;
    case (m_cell[i])
      1:       return 3'b100;
      2:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 9; i++) chk($sformatf("color%0d", i), 8'(dut_col[i]), 8'(exp_col(i)));
      chk("turn", 8'(turn), 8'(m_turn));
      chk("game_over", 8'(game_over), 8'(m_over));
      chk("winner", 8'(winner), 8'(m_winner));
      chk("bad_move", 8'(bad_move), 8'(m_bad));
    end
  end

  task automatic cyc(input int s, input bit p, input bit n);
    @(negedge clk);
    rst = 1'b1; cell_sel = 4'(s); place = p; new_game = n;
    @(posedge clk);
    model_step(s, p, n);
  endtask

  // Press edge, check edge, idle edge.
  task automatic move(input int s);
    cyc(s, 1, 0);
    cyc(s, 0, 0);
    cyc(s, 0, 0);
  endtask

  initial begin
    int seq_row[5]  = '{0, 3, 1, 4, 2};
    int seq_diag[6] = '{1, 2, 3, 4, 8, 6};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int s;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A1", 8'(A1_color), 8'h0);
    chk("rst_C3", 8'(C3_color), 8'h0);
    chk("rst_turn", 8'(turn), 8'h0);
    chk("rst_over", 8'(game_over), 8'h0);
    chk("rst_winner", 8'(winner), 8'h0);
    chk_en = 1'b1;

    // Single move with held button: one press only.
    cyc(4, 1, 0);
    #1 chk("b2_after1", 8'(B2_color), 8'h4);
    chk("turn_after1", 8'(turn), 8'h0);
    repeat (4) cyc(4, 1, 0);
    cyc(4, 0, 0);
    #1 chk("turn_after2", 8'(turn), 8'h1);
    chk("b2_held", 8'(B2_color), 8'h4);

    // Re-press occupied cell, then illegal index.
    cyc(4, 1, 0);
    #1 chk("bad_occ", 8'(bad_move), 8'h1);
    cyc(4, 0, 0);
    cyc(12, 1, 0);
    #1 chk("bad_idx", 8'(bad_move), 8'h1);
    cyc(12, 0, 0);
    #1 chk("turn_kept", 8'(turn), 8'h1);

    // P1 row win.
    cyc(0, 0, 1);
    foreach (seq_row[i]) move(seq_row[i]);
    #1 chk("row_winner", 8'(winner), 8'h1);
    chk("row_over", 8'(game_over), 8'h1);
    chk("row_A1", 8'(A1_color), 8'h2);
    chk("row_A3", 8'(A3_color), 8'h2);
    chk("row_B1", 8'(B1_color), 8'h1);
    move(8);
    #1 chk("row_C3_ign", 8'(C3_color), 8'h0);

    // P2 anti-diagonal win.
    cyc(0, 0, 1);
    foreach (seq_diag[i]) move(seq_diag[i]);
    #1 chk("diag_winner", 8'(winner), 8'h2);
    chk("diag_A3", 8'(A3_color), 8'h2);
    chk("diag_C1", 8'(C1_color), 8'h2);
    chk("diag_A2", 8'(A2_color), 8'h4);

    // Draw.
    cyc(0, 0, 1);
    foreach (seq_draw[i]) move(seq_draw[i]);
    #1 chk("draw_winner", 8'(winner), 8'h3);
    chk("draw_over", 8'(game_over), 8'h1);
    chk("draw_B2", 8'(B2_color), 8'h1);

    // new_game beats a simultaneous legal press.
    cyc(4, 1, 1);
    #1 chk("ng_B2", 8'(B2_color), 8'h0);
    chk("ng_over", 8'(game_over), 8'h0);
    cyc(4, 0, 0);
    cyc(4, 0, 0);
    #1 chk("ng_turn", 8'(turn), 8'h0);

    // Reset while the move is being checked.
    cyc(0, 1, 0);
    #2 rst = 1'b0;
    model_reset();
    #1 chk("rst_mid_A1", 8'(A1_color), 8'h0);
    chk("rst_mid_turn", 8'(turn), 8'h0);
    cyc(0, 0, 0);

    // Randomized play.
    for (int it = 0; it < 3000; it++) begin
      s = ($urandom % 5 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      cyc(s, bit'($urandom % 2), ($urandom % 60) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Game-state controller for the 3x3 tic-tac-toe board.
- Sits directly upstream of the VGA display block.
- Accepts cell-select and place/new-game buttons, then tracks occupancy, turn, move count and win/draw.
- Drives the nine 3-bit per-cell colour buses (A1..C3) that the display block paints.

Parameters:
- EMPTY_COLOR, 3'b000, colour of an unoccupied cell.
- P1_COLOR, 3'b100, colour of a player-1 cell (red).
- P2_COLOR, 3'b001, colour of a player-2 cell (blue).
- WIN_COLOR, 3'b010, colour of the three winning cells after a win (green).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cell_sel  in  4  target cell index; 0=A1, 1=A2, 2=A3, 3=B1 … 8=C3; 9-15 are illegal
- place  in  1  place button, active-high level, synchronous to clk
- new_game  in  1  clear-board request, active-high level
- A1_color … C3_color  out  3 each  per-cell colour, registered (nine ports)
- turn  out  1  player to move; 0 = P1, 1 = P2
- game_over  out  1  high in WIN or DRAW
- winner  out  2  00 = none, 01 = P1, 10 = P2, 11 = draw
- bad_move  out  1  one-cycle pulse on a rejected press

Behaviour:
- Reset (rst=0, async): all cells empty, turn=0, move_cnt=0, state=PLAY, winner=00, game_over=0, bad_move=0, all colors=EMPTY_COLOR, place_q=0.
- Cell storage: 9 x 2-bit codes; 00 empty, 01 P1, 10 P2. move_cnt is 4 bits, range 0..9.
- Press detect: press = place & ~place_q. place_q is place registered every clk, so a held button yields exactly one press.
- States: PLAY, CHECK, WIN, DRAW.
- new_game (any state): clears the board exactly as reset does on that edge and enters PLAY. It has priority over a press in the same cycle.
- PLAY:
  - A press with cell_sel<=8 and the selected cell empty writes the turn's code into that cell, increments move_cnt and goes to CHECK, all on the same edge.
  - A press with cell_sel>8 or an occupied cell leaves the board, turn and state unchanged and pulses bad_move high for exactly one cycle.
- CHECK (exactly one cycle):
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the current turn's code.
  - Any line complete -> WIN: winner = turn+1, win_mask latched to the cells of the first complete line in order rows, cols, diag(A1-C3), diag(A3-C1).
  - Else move_cnt==9 -> DRAW: winner = 11.
  - Else toggle turn and return to PLAY.
- Latency: the board/colour update is visible 1 cycle after the press edge. turn, game_over and winner update at the end of CHECK, 2 edges after the press edge.
- WIN, DRAW: presses are ignored with no bad_move; the state is held until new_game or reset.
- Colour mapping (registered, every cycle):
  - In WIN, a cell set in win_mask shows WIN_COLOR.
  - Otherwise the colour follows the cell code: empty -> EMPTY_COLOR, P1 -> P1_COLOR, P2 -> P2_COLOR.
- game_over = (state==WIN || state==DRAW). It is registered and consistent with winner.
- A press arriving while in CHECK is discarded; place_q still updates.
- Reset mid-game clears all state immediately, regardless of the current state.

Decomposition:
- Shared package ttt_pkg holds:
  - cell codes (EMPTY/P1/P2)
  - state encodings
  - default colour constants
  - the 8-entry line table of cell-index triples
  - the winner encodings
- Sub-module ttt_line_check: purely combinational. Inputs are the 18-bit board and a 2-bit player code. Outputs are win (1) and win_mask (9). It is instantiated once in CHECK logic.

Test Plan:
- Reset, then read outputs -> all colors 3'b000, turn=0, game_over=0, winner=00.
- Single move:
  - cell_sel=4, place held 5 cycles -> B2_color=3'b100 after 1 cycle, turn=1 after 2 cycles, move_cnt=1 (one press only).
  - Re-press cell 4 -> bad_move pulses 1 cycle, board unchanged, turn stays 1.
  - cell_sel=12 -> bad_move pulse, no change.
- P1 row win: P1 A1, P2 B1, P1 A2, P2 B2, P1 A3 -> winner=01, game_over=1, A1/A2/A3=3'b010, B1/B2=3'b001; a further press on C3 has no effect.
- Diagonal win for P2: P1 A2, P2 A3, P1 B1, P2 B2, P1 C3, P2 C1 -> winner=10, win_mask = A3, B2, C1 shown 3'b010.
- Draw: sequence A1,A2,A3,B2,B1,B3,C2,C1,C3 -> after the 9th move winner=11, game_over=1, no WIN_COLOR anywhere.
- Control and reset priority:
  - new_game asserted in the same cycle as a legal press -> board cleared, press ignored, state PLAY, turn=0.
  - rst pulsed low during CHECK -> immediate full clear.
